cond_unit_it: RTL and testbench

- Sequential successor to the combinational condition check in the single-cycle ARM datapath.
- Holds the architectural NZCV flag register and gates a parametrised vector of write/branch controls with the evaluated condition.
- Adds a Thumb-style IT-block sequencer: up to 4 following instructions are predicated by a captured condition with per-slot then/else polarity.
- Sits between the decoder and the register file, memory and PC write enables.

---
 rtl/cond_unit_it.sv | 157 +++++++++++++++
 tb/tb_cond_unit_it.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/cond_unit_it.sv
// ARM condition unit with NZCV flag register and Thumb-style IT sequencer.
// Gates decoder write/branch enables with the evaluated condition.
module cond_unit_it #(
  parameter int NUM_CTRL = 3,
  parameter int REGW_IDX = 1,
  parameter bit REG_OUT  = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic [3:0]          cond,
  input  logic [3:0]          alu_flags,
  input  logic [1:0]          flag_w,
  input  logic [NUM_CTRL-1:0] ctrl_in,
  input  logic                no_write,
  input  logic                it_start,
  input  logic [3:0]          it_firstcond,
  input  logic [2:0]          it_len,
  input  logic [2:0]          it_else,
  output logic                cond_ex,
  output logic [NUM_CTRL-1:0] ctrl_out,
  output logic [3:0]          flags,
  output logic                it_active,
  output logic [2:0]          it_remaining
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t              state_q, state_d;
  logic [3:0]          flags_q, flags_d;
  logic [2:0]          rem_q, rem_d;
  logic [3:0]          fc_q, fc_d;
  logic                inv_q, inv_d;
  logic [2:0]          sh_q, sh_d;
  logic [3:0]          ec;
  logic                pass;
  logic                cex_c;
  logic [NUM_CTRL-1:0] ctrl_c;
  logic [2:0]          else_msk;
  logic                len_ok;
  logic                it_ok;

  function automatic logic cond_ok(
    input logic [3:0] c,
    input logic [3:0] f
  );
    logic n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'b0000: cond_ok = z;
      4'b0001: cond_ok = !z;
      4'b0010: cond_ok = cy;
      4'b0011: cond_ok = !cy;
      4'b0100: cond_ok = n;
      4'b0101: cond_ok = !n;
      4'b0110: cond_ok = v;
      4'b0111: cond_ok = !v;
      4'b1000: cond_ok = cy & !z;
      4'b1001: cond_ok = !cy | z;
      4'b1010: cond_ok = (n == v);
      4'b1011: cond_ok = (n != v);
      4'b1100: cond_ok = !z & (n == v);
      4'b1101: cond_ok = z | (n != v);
      default: cond_ok = 1'b1;
    endcase
  endfunction

  // Else bits that belong to slots 2..len of the requested block
  always_comb begin
    case (it_len)
      3'd2:    else_msk = 3'b001;
      3'd3:    else_msk = 3'b011;
      3'd4:    else_msk = 3'b111;
      default: else_msk = 3'b000;
    endcase
  end

  assign len_ok = (it_len != 3'd0) && (it_len <= 3'd4);
  assign it_ok  = len_ok &&
                  !((it_firstcond == 4'b1110) && (|(it_else & else_msk)));

  // inv_q is the polarity of the current slot; sh_q queues the later ones
  always_comb begin
    state_d = state_q;
    flags_d = flags_q;
    rem_d   = rem_q;
    fc_d    = fc_q;
    inv_d   = inv_q;
    sh_d    = sh_q;
    ec      = (state_q == ACTIVE) ? {fc_q[3:1], fc_q[0] ^ inv_q} : cond;
    pass    = cond_ok(ec, flags_q);
    cex_c   = ((state_q == IDLE) && it_start) ? 1'b1 : pass;
    ctrl_c  = ctrl_in & {NUM_CTRL{cex_c & en}};
    if (no_write) ctrl_c[REGW_IDX] = 1'b0;
    if (it_start) ctrl_c = '0;
    if (en && cex_c) begin
      if (flag_w[1]) flags_d[3:2] = alu_flags[3:2];
      if (flag_w[0]) flags_d[1:0] = alu_flags[1:0];
    end
    if (en) begin
      if (state_q == ACTIVE) begin
        rem_d = rem_q - 3'd1;
        inv_d = sh_q[0];
        sh_d  = sh_q >> 1;
        if (rem_q == 3'd1) state_d = IDLE;
      end else if (it_start && it_ok) begin
        state_d = ACTIVE;
        rem_d   = it_len;
        fc_d    = it_firstcond;
        inv_d   = 1'b0;
        sh_d    = it_else;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      flags_q <= '0;
      rem_q   <= '0;
      fc_q    <= '0;
      inv_q   <= 1'b0;
      sh_q    <= '0;
    end else begin
      state_q <= state_d;
      flags_q <= flags_d;
      rem_q   <= rem_d;
      fc_q    <= fc_d;
      inv_q   <= inv_d;
      sh_q    <= sh_d;
    end
  end

  assign flags        = flags_q;
  assign it_active    = (state_q == ACTIVE);
  assign it_remaining = rem_q;

  if (REG_OUT) begin : g_reg
    logic                cex_q;
    logic [NUM_CTRL-1:0] ctrl_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cex_q  <= 1'b0;
        ctrl_q <= '0;
      end else begin
        cex_q  <= cex_c;
        ctrl_q <= ctrl_c;
      end
    end
    assign cond_ex  = cex_q;
    assign ctrl_out = ctrl_q;
  end else begin : g_comb
    assign cond_ex  = cex_c;
    assign ctrl_out = ctrl_c;
  end

endmodule

// File: tb/tb_cond_unit_it.sv
// Bench for cond_unit_it: directed plan plus random traffic vs a
// queue-based reference model; a REG_OUT=1 copy checks the output lag.
module tb_cond_unit_it;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [3:0] cond, alu_flags, it_firstcond;
  logic [1:0] flag_w;
  logic [2:0] ctrl_in, it_len, it_else;
  logic       no_write, it_start;

  logic       cx0, cx1, act0, act1;
  logic [2:0] ct0, ct1, rem0, rem1;
  logic [3:0] fl0, fl1;

  int n_chk  = 0;
  int n_pass = 0;

  logic [3:0] m_flags;
  logic [3:0] m_q[$];
  logic       r_cex;
  logic [2:0] r_ctrl;

  always #5 clk = ~clk;

  cond_unit_it #(.NUM_CTRL(3), .REGW_IDX(1), .REG_OUT(1'b0)) u0 (
    .clk(clk), .rst_n(rst_n), .en(en), .cond(cond),
    .alu_flags(alu_flags), .flag_w(flag_w), .ctrl_in(ctrl_in),
    .no_write(no_write), .it_start(it_start),
    .it_firstcond(it_firstcond), .it_len(it_len), .it_else(it_else),
    .cond_ex(cx0), .ctrl_out(ct0), .flags(fl0),
    .it_active(act0), .it_remaining(rem0)
  );

  cond_unit_it #(.NUM_CTRL(3), .REGW_IDX(1), .REG_OUT(1'b1)) u1 (
    .clk(clk), .rst_n(rst_n), .en(en), .cond(cond),
    .alu_flags(alu_flags), .flag_w(flag_w), .ctrl_in(ctrl_in),
    .no_write(no_write), .it_start(it_start),
    .it_firstcond(it_firstcond), .it_len(it_len), .it_else(it_else),
    .cond_ex(cx1), .ctrl_out(ct1), .flags(fl1),
    .it_active(act1), .it_remaining(rem1)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // Base test on cond[3:1], cond[0] inverts it (except AL/NV)
  function automatic bit holds(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v, r;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c[3:1])
      3'd0: r = z;
      3'd1: r = cy;
      3'd2: r = n;
      3'd3: r = v;
      3'd4: r = cy && !z;
      3'd5: r = (n == v);
      3'd6: r = !z && (n == v);
      default: r = 1'b1;
    endcase
    if (c[3:1] != 3'd7 && c[0]) r = !r;
    return r;
  endfunction

  function automatic bit it_legal(input logic [3:0] fc, input int len,
                                  input logic [2:0] el);
    if (len < 1 || len > 4) return 0;
    if (fc == 4'b1110)
      for (int i = 0; i < len - 1; i++) if (el[i]) return 0;
    return 1;
  endfunction

  task automatic model_reset();
    m_flags = 4'b0000;
    m_q.delete();
    r_cex  = 1'b0;
    r_ctrl = 3'b000;
  endtask

  task automatic drive(input bit e, input logic [3:0] c,
                       input logic [3:0] af, input logic [1:0] fw,
                       input logic [2:0] ci, input bit nw, input bit is,
                       input logic [3:0] fc, input logic [2:0] ln,
                       input logic [2:0] el);
    en = e; cond = c; alu_flags = af; flag_w = fw; ctrl_in = ci;
    no_write = nw; it_start = is; it_firstcond = fc;
    it_len = ln; it_else = el;
  endtask

  // Called at a negedge with inputs set; returns at the next negedge
  task automatic step(input string tag);
    logic [3:0] ec;
    logic [2:0] ctl;
    bit         act, cx;
    act = (m_q.size() != 0);
    ec  = act ? m_q[0] : cond;
    cx  = (!act && it_start) ? 1'b1 : holds(ec, m_flags);
    ctl = (cx && en) ? ctrl_in : 3'b000;
    if (no_write) ctl[1] = 1'b0;
    if (it_start) ctl = 3'b000;
    #1;
    chk({tag, ".cex"}, cx0, cx);
    chk({tag, ".ctrl"}, ct0, ctl);
    chk({tag, ".flags"}, fl0, m_flags);
    chk({tag, ".act"}, act0, act);
    chk({tag, ".rem"}, rem0, m_q.size());
    chk({tag, ".rcex"}, cx1, r_cex);
    chk({tag, ".rctrl"}, ct1, r_ctrl);
    chk({tag, ".rrem"}, rem1, m_q.size());
    if (en) begin
      if (cx) begin
        if (flag_w[1]) m_flags[3:2] = alu_flags[3:2];
        if (flag_w[0]) m_flags[1:0] = alu_flags[1:0];
      end
      if (act) void'(m_q.pop_front());
      else if (it_start && it_legal(it_firstcond, int'(it_len), it_else)) begin
        m_q.push_back(it_firstcond);
        for (int k = 2; k <= int'(it_len); k++)
          m_q.push_back({it_firstcond[3:1], it_firstcond[0] ^ it_else[k-2]});
      end
    end
    r_cex  = cx;
    r_ctrl = ctl;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 4'h0, 4'h0, 2'b00, 3'b000, 0, 0, 4'h0, 3'd0, 3'b000);
    model_reset();
    #2;
    chk("rst.flags", fl0, 4'b0000);
    chk("rst.act", act0, 1'b0);
    chk("rst.rem", rem0, 3'd0);
    chk("rst.rcex", cx1, 1'b0);
    chk("rst.rctrl", ct1, 3'b000);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    drive(1, 4'b0000, 4'h0, 2'b00, 3'b111, 0, 0, 4'h0, 3'd0, 3'b000);
    step("eq_z0");
    drive(1, 4'b1110, 4'b0100, 2'b11, 3'b111, 0, 0, 4'h0, 3'd0, 3'b000);
    step("adds");
    drive(1, 4'b0000, 4'h0, 2'b00, 3'b111, 0, 0, 4'h0, 3'd0, 3'b000);
    step("eq_z1");

    drive(1, 4'b1110, 4'b1001, 2'b11, 3'b000, 0, 0, 4'h0, 3'd0, 3'b000);
    step("set_nv");
    for (int c = 10; c <= 12; c++) begin
      drive(1, 4'(c), 4'h0, 2'b00, 3'b111, 0, 0, 4'h0, 3'd0, 3'b000);
      step($sformatf("sgn%0d", c));
    end
    drive(1, 4'b1110, 4'b1100, 2'b10, 3'b000, 0, 0, 4'h0, 3'd0, 3'b000);
    step("set_z");
    drive(1, 4'b1101, 4'h0, 2'b00, 3'b111, 0, 0, 4'h0, 3'd0, 3'b000);
    step("le");

    drive(1, 4'b1110, 4'h0, 2'b00, 3'b000, 0, 1, 4'b0000, 3'd3, 3'b010);
    step("it3");
    drive(1, 4'b1110, 4'b0000, 2'b10, 3'b101, 1, 0, 4'h0, 3'd0, 3'b000);
    step("slot1_cmp");
    drive(1, 4'b1110, 4'h0, 2'b00, 3'b111, 0, 0, 4'h0, 3'd0, 3'b000);
    step("slot2");
    step("slot3");
    step("after_it");

    drive(1, 4'b0000, 4'b1111, 2'b11, 3'b111, 0, 0, 4'h0, 3'd0, 3'b000);
    step("failcond");
    drive(1, 4'b1110, 4'h0, 2'b00, 3'b111, 1, 0, 4'h0, 3'd0, 3'b000);
    step("nowrite");

    drive(1, 4'b1110, 4'h0, 2'b00, 3'b111, 0, 1, 4'b1110, 3'd2, 3'b001);
    step("it_ill_al");
    drive(1, 4'b1110, 4'h0, 2'b00, 3'b111, 0, 1, 4'b0001, 3'd0, 3'b000);
    step("it_len0");
    drive(1, 4'b1110, 4'h0, 2'b00, 3'b111, 0, 1, 4'b0001, 3'd5, 3'b000);
    step("it_len5");

    drive(1, 4'b1110, 4'b1010, 2'b11, 3'b000, 0, 0, 4'h0, 3'd0, 3'b000);
    step("set_flags");
    drive(1, 4'b1110, 4'h0, 2'b00, 3'b000, 0, 1, 4'b1110, 3'd4, 3'b000);
    step("it4");
    drive(1, 4'b1110, 4'h0, 2'b00, 3'b011, 0, 0, 4'h0, 3'd0, 3'b000);
    step("it4_s1");
    drive(0, 4'b1110, 4'b0101, 2'b11, 3'b111, 0, 0, 4'h0, 3'd0, 3'b000);
    for (int i = 0; i < 3; i++) step($sformatf("stall%0d", i));
    drive(1, 4'b1110, 4'h0, 2'b00, 3'b011, 0, 0, 4'h0, 3'd0, 3'b000);
    step("it4_s2");
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("arst.flags", fl0, 4'b0000);
    chk("arst.act", act0, 1'b0);
    chk("arst.rem", rem0, 3'd0);
    chk("arst.rcex", cx1, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 600; i++) begin
      logic [3:0] fc;
      logic [2:0] ln;
      fc = ($urandom_range(0, 3) == 0) ? 4'b1110 : 4'($urandom);
      ln = ($urandom_range(0, 5) == 0) ? 3'($urandom)
                                       : 3'($urandom_range(1, 4));
      drive($urandom_range(0, 6) != 0, 4'($urandom), 4'($urandom),
            2'($urandom), 3'($urandom), $urandom_range(0, 4) == 0,
            $urandom_range(0, 7) == 0, fc, ln, 3'($urandom));
      step($sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
